// File: rtl/pipelined_pkg.sv
// Shared definitions for the pipelined MIPS core: opcodes, ISR vector and
// interrupt controller state encoding.
package pipelined_pkg;

  localparam logic [5:0]  OpReti     = 6'h1E;
  localparam logic [5:0]  FunctSetie = 6'h1F;
  localparam logic [31:0] IsrVector  = 32'h0000_03FC;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StIsr
  } state_e;

endpackage

// File: rtl/interrupt_ctrl.sv
// Interrupt controller feeding intr/IE to the decode-stage control unit; owns IE,
// captures EPC, drives the fetch flush while the ISR vector load drains.
module interrupt_ctrl
  import pipelined_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [5:0]  RETI_OP      = OpReti
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intr_req,
  output logic        intr_ack,
  input  logic        stall,
  input  logic [31:0] ir_id,
  input  logic [31:0] pc_id,
  input  logic        new_IE,
  output logic        IE,
  output logic        intr,
  output logic        flush,
  output logic [31:0] epc,
  output logic        in_isr
);

  localparam logic [2:0] CntInit = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic        ack_q, ack_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;

  logic accept;
  logic reti;

  // Only the opcode field matters here; the rest of the word belongs to the decoder.
  logic unused_ir;
  assign unused_ir = ^ir_id[25:0];

  assign reti   = (ir_id[31:26] == RETI_OP);
  assign accept = (state_q == StRun) & pending_q & ie_q & ~stall;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (accept) state_d = StFlush;
      StFlush: if ((cnt_q == 3'd0) && !stall) state_d = StIsr;
      StIsr:   if (reti && !stall) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Outputs
  always_comb begin
    intr     = pending_q & (state_q == StRun);
    flush    = (state_q == StFlush);
    in_isr   = (state_q != StRun);
    IE       = ie_q;
    intr_ack = ack_q;
    epc      = epc_q;
  end

  // Datapath next-state: IE, pending latch, flush counter, EPC, ack pulse
  always_comb begin
    ie_d      = ie_q;
    cnt_d     = cnt_q;
    pending_d = accept ? 1'b0 : (pending_q | intr_req);
    epc_d     = accept ? pc_id : epc_q;
    ack_d     = accept;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          ie_d  = 1'b0;
          cnt_d = CntInit;
        end else if (!stall) begin
          ie_d = new_IE;
        end
      end
      StFlush: begin
        ie_d = 1'b0;
        if (!stall && (cnt_q != 3'd0)) cnt_d = cnt_q - 3'd1;
      end
      StIsr: begin
        // RETI forces IE back on regardless of what the decoder asks for
        if (!stall) ie_d = reti ? 1'b1 : new_IE;
      end
      default: ie_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      cnt_q     <= 3'd0;
      epc_q     <= 32'd0;
    end else begin
      ie_q      <= ie_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
      epc_q     <= epc_d;
    end
  end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt controller for the pipelined MIPS core; sits directly upstream of the decode-stage control unit and feeds it the `intr` and `IE` inputs. It owns the IE flag register and consumes the decoder's `new_IE` output. It latches device interrupt requests and captures the return PC (EPC) of the squashed decode-stage instruction. It also drives a fixed-length fetch flush while the ISR vector load (dMEM[0x3FC] → PC) drains through the pipeline, and restores IE on RETI.

## Interface
- `FLUSH_CYCLES`, default 3: unstalled cycles `flush` is held after acceptance; legal range 1..7.
- `RETI_OP`, default 6'h1E: opcode field (IR[31:26]) identifying RETI.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `intr_req`  in  1  level interrupt request from I/O; device holds it until `intr_ack`.
- `intr_ack`  out  1  one-cycle acknowledge pulse to the device.
- `stall`  in  1  decode stage stalled; no state advances that depend on an instruction retiring from ID.
- `ir_id`  in  32  instruction currently in ID (same word the control unit decodes).
- `pc_id`  in  32  PC of `ir_id`.
- `new_IE`  in  1  next IE value from the control unit.
- `IE`  out  1  current IE flag, to control unit.
- `intr`  out  1  interrupt pending toward control unit.
- `flush`  out  1  squash IF/ID contents and suppress PC increment.
- `epc`  out  32  return address captured at acceptance.
- `in_isr`  out  1  high from acceptance until RETI retires.

## Operation
- States: RUN, FLUSH, ISR. `in_isr` = (state != RUN).
- Reset values: state RUN, `IE`=0, pending=0, `intr`=0, `intr_ack`=0, `flush`=0, `epc`=0, `in_isr`=0, flush counter=0.
- pending register: set when `intr_req`=1; cleared on the acceptance edge. Clear wins over set in the same cycle.
- `intr` = pending & (state==RUN). It is combinational from registers and is never asserted outside RUN, so nesting is impossible.
- Acceptance: state==RUN & pending & `IE` & ~`stall`. On that edge:
  - state→FLUSH
  - `IE`←0 (`new_IE` is ignored this cycle)
  - `epc`←`pc_id`
  - pending←0
  - `intr_ack`←1
  - counter←FLUSH_CYCLES−1
- RUN, no acceptance: `IE`←`new_IE` when ~`stall`; hold when stalled.
- RUN with `stall`=1 and pending & `IE`: `intr` stays asserted and acceptance waits for the first unstalled cycle.
- FLUSH:
  - `flush`=1, `IE` held at 0.
  - Counter decrements on unstalled cycles and holds when stalled.
  - At counter==0 & ~`stall`, state→ISR.
- ISR: `IE`←`new_IE` on unstalled cycles, so SETIE is honoured but still masked by state. When `ir_id`[31:26]==RETI_OP & ~`stall`: state→RUN and `IE`←1, overriding `new_IE`.
- RETI decoded in RUN: no special action; normal `IE`←`new_IE` applies.
- `intr_ack` is a registered pulse, high exactly one cycle after the acceptance edge, then 0.
- `reset`, including mid-FLUSH or mid-ISR, forces all reset values on the next edge regardless of other inputs.

## Timing
- `intr_req` high in cycle t → pending=1 and `intr`=1 in t+1 (state RUN).
- Acceptance cycle A: the control unit emits the ISR control word in A.
- `intr_ack`=1 in A+1 only.
- `flush`=1 in A+1..A+FLUSH_CYCLES with no stalls; each stall cycle extends the window by one.
- ISR state from A+FLUSH_CYCLES+1; `epc` is valid from A+1 and stable until the next acceptance.
- RETI retiring from ID in cycle R → `IE`=1, `in_isr`=0, and `intr` may re-assert in R+1. Back-to-back interrupts therefore have at least one RUN cycle between them.

## Structure
- Shared package `pipelined_pkg`: opcode constants (RETI 6'h1E, SETIE funct 6'h1F), ISR vector address 0x3FC, state enum {RUN, FLUSH, ISR}.
- Single module, no sub-module; the 3-bit flush counter and FSM are inline.

## Test plan
- Reset with `intr_req`=1 held: all outputs 0 during reset; after release with `IE`=0 (`new_IE`=0), `intr`=1 and no acceptance, `intr_ack` stays 0.
- `new_IE`=1 (SETIE), `intr_req` pulse at cycle 10, `pc_id`=0x0000_0040, no stall → `intr`=1 at 11; `intr_ack`=1 at 12; `epc`=0x40; `flush`=1 at 12..14; ISR at 15; `IE`=0.
- Same as previous, but `stall`=1 for 2 cycles during FLUSH → `flush` high for 5 cycles and ISR entered 2 cycles later.
- In ISR, drive `ir_id`={6'h1E,26'b0} with `stall`=1 then 0 → no change while stalled; next edge state RUN, `IE`=1, `in_isr`=0.
- `intr_req` held high in ISR plus SETIE executed → `intr` stays 0 until RETI; re-asserts the cycle after RETI; second acceptance occurs.
- Assert `reset` during FLUSH (counter=1) → next edge all outputs at reset values, `flush`=0, `epc`=0.
